// File: rtl/ram_arb.sv
// Two-requester (CPU / DMA) arbiter in front of a single synchronous RAM port.
// Optional DMA burst lock is compiled in with `define RAM_ARB_BURST_EN.
module ram_arb #(
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_CPU_req,
  input  logic              i_CPU_we,
  input  logic [1:0]        i_CPU_be,
  input  logic [ADDR_W-1:0] i_CPU_addr,
  input  logic [DATA_W-1:0] i_CPU_write,
  output logic [DATA_W-1:0] o_CPU_read,
  output logic              o_CPU_ack,
  input  logic              i_DMA_req,
  input  logic              i_DMA_we,
  input  logic [1:0]        i_DMA_be,
  input  logic [ADDR_W-1:0] i_DMA_addr,
  input  logic [DATA_W-1:0] i_DMA_write,
  input  logic              i_DMA_lock,
  output logic [DATA_W-1:0] o_DMA_read,
  output logic              o_DMA_ack,
  output logic [ADDR_W-1:0] o_RAM_addr,
  output logic [DATA_W-1:0] o_RAM_write,
  output logic              o_RAM_we,
  output logic [1:0]        o_RAM_be,
  input  logic [DATA_W-1:0] i_RAM_read
);

  typedef enum logic [1:0] {IDLE, GRANT, DATA} state_t;

  state_t              state_q, state_d;
  logic                win_dma_q, win_dma_d;
  logic                win_we_q, win_we_d;
  logic                last_dma_q, last_dma_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [1:0]          be_q, be_d;
  logic                grant, sel_dma, lock_win;

`ifdef RAM_ARB_BURST_EN
  localparam int BW = $clog2(MAX_BURST + 1);
  logic [BW-1:0] burst_cnt_q;

  // DMA keeps the port while it holds lock, up to MAX_BURST grants taken from a waiting CPU
  assign lock_win = last_dma_q & i_DMA_lock & i_DMA_req & (burst_cnt_q < BW'(MAX_BURST));

  always_ff @(posedge clk) begin
    if (reset)
      burst_cnt_q <= '0;
    else if (grant) begin
      if (sel_dma && i_DMA_lock) begin
        if (i_CPU_req) burst_cnt_q <= burst_cnt_q + BW'(1);
      end else
        burst_cnt_q <= '0;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = i_DMA_lock;
  assign lock_win    = 1'b0;
`endif

  assign grant   = (state_q == IDLE) & (i_CPU_req | i_DMA_req);
  assign sel_dma = i_DMA_req & (~i_CPU_req | ~last_dma_q | lock_win);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      win_dma_q  <= 1'b0;
      win_we_q   <= 1'b0;
      last_dma_q <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      be_q       <= 2'b00;
    end else begin
      state_q    <= state_d;
      win_dma_q  <= win_dma_d;
      win_we_q   <= win_we_d;
      last_dma_q <= last_dma_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      be_q       <= be_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    win_dma_d  = win_dma_q;
    win_we_d   = win_we_q;
    last_dma_d = last_dma_q;
    case (state_q)
      IDLE: if (grant) begin
        state_d    = GRANT;
        win_dma_d  = sel_dma;
        win_we_d   = sel_dma ? i_DMA_we : i_CPU_we;
        last_dma_d = sel_dma;
      end
      GRANT:   state_d = DATA;
      DATA:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM command is registered on the grant edge so it is stable for the whole GRANT cycle
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    be_d    = 2'b00;
    if (grant) begin
      addr_d  = sel_dma ? i_DMA_addr  : i_CPU_addr;
      wdata_d = sel_dma ? i_DMA_write : i_CPU_write;
      we_d    = sel_dma ? i_DMA_we    : i_CPU_we;
      be_d    = sel_dma ? i_DMA_be    : i_CPU_be;
    end
  end

  assign o_RAM_addr  = addr_q;
  assign o_RAM_write = wdata_q;
  assign o_RAM_we    = we_q;
  assign o_RAM_be    = be_q;

  assign o_CPU_ack  = (state_q == DATA) & ~win_dma_q;
  assign o_DMA_ack  = (state_q == DATA) &  win_dma_q;
  assign o_CPU_read = (o_CPU_ack & ~win_we_q) ? i_RAM_read : '0;
  assign o_DMA_read = (o_DMA_ack & ~win_we_q) ? i_RAM_read : '0;

endmodule

// File: tb/tb_ram_arb.sv
// Scoreboard bench for ram_arb: directed accesses push expected acks, a negedge monitor checks them.
module tb_ram_arb;
  localparam int AW = 18;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_CPU_req, i_CPU_we, i_DMA_req, i_DMA_we, i_DMA_lock;
  logic [1:0]    i_CPU_be, i_DMA_be, o_RAM_be;
  logic [AW-1:0] i_CPU_addr, i_DMA_addr, o_RAM_addr;
  logic [DW-1:0] i_CPU_write, i_DMA_write, o_CPU_read, o_DMA_read, o_RAM_write, i_RAM_read;
  logic          o_CPU_ack, o_DMA_ack, o_RAM_we;

  ram_arb #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(8)) dut (
    .clk(clk), .reset(reset),
    .i_CPU_req(i_CPU_req), .i_CPU_we(i_CPU_we), .i_CPU_be(i_CPU_be),
    .i_CPU_addr(i_CPU_addr), .i_CPU_write(i_CPU_write),
    .o_CPU_read(o_CPU_read), .o_CPU_ack(o_CPU_ack),
    .i_DMA_req(i_DMA_req), .i_DMA_we(i_DMA_we), .i_DMA_be(i_DMA_be),
    .i_DMA_addr(i_DMA_addr), .i_DMA_write(i_DMA_write), .i_DMA_lock(i_DMA_lock),
    .o_DMA_read(o_DMA_read), .o_DMA_ack(o_DMA_ack),
    .o_RAM_addr(o_RAM_addr), .o_RAM_write(o_RAM_write), .o_RAM_we(o_RAM_we),
    .o_RAM_be(o_RAM_be), .i_RAM_read(i_RAM_read)
  );

  always #5 clk = ~clk;

  // RAM model: byte-masked write, read data one cycle after the address
  logic [15:0] mem [0:255];
  always @(posedge clk) begin
    if (o_RAM_we) begin
      if (o_RAM_be[1]) mem[o_RAM_addr[7:0]][15:8] <= o_RAM_write[15:8];
      if (o_RAM_be[0]) mem[o_RAM_addr[7:0]][7:0]  <= o_RAM_write[7:0];
    end
    i_RAM_read <= mem[o_RAM_addr[7:0]];
  end

  typedef struct {
    bit          dma;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_ack_cyc = -10;
  int   ack_cycs[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_ack(input bit dma, input logic [15:0] d);
    exp_t e;
    e.dma  = dma;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every ack is popped against the scoreboard in order
  always @(negedge clk) begin
    if (!reset && (o_CPU_ack || o_DMA_ack)) begin
      checks++;
      if (o_CPU_ack && o_DMA_ack) begin
        errors++;
        $display("FAIL ack_excl: both acks high at cycle %0d", cyc);
      end else if (cyc - last_ack_cyc < 2) begin
        errors++;
        $display("FAIL ack_gap: acks at cycles %0d and %0d", last_ack_cyc, cyc);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: cpu=%0b dma=%0b at cycle %0d", o_CPU_ack, o_DMA_ack, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (o_DMA_ack !== mon_e.dma ||
            (o_DMA_ack ? o_DMA_read : o_CPU_read) !== mon_e.data ||
            (o_DMA_ack ? o_CPU_read : o_DMA_read) !== 16'h0) begin
          errors++;
          $display("FAIL ack_data: got dma=%0b rd=%0h other=%0h expected dma=%0b rd=%0h other=0",
                   o_DMA_ack, o_DMA_ack ? o_DMA_read : o_CPU_read,
                   o_DMA_ack ? o_CPU_read : o_DMA_read, mon_e.dma, mon_e.data);
        end
      end
      last_ack_cyc = cyc;
      ack_cycs.push_back(cyc);
    end
  end

  // Presents one access, waits for its ack; keeps req high afterwards unless last is set.
  // Called at posedge+1; returns at posedge+1 of the cycle after the ack.
  task automatic acc(input bit dma, input bit we, input logic [1:0] be, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wd, input bit lock, input bit last, input bit chk_cmd);
    bit got;
    if (dma) begin
      i_DMA_req = 1'b1; i_DMA_we = we; i_DMA_be = be; i_DMA_addr = addr;
      i_DMA_write = wd; i_DMA_lock = lock;
    end else begin
      i_CPU_req = 1'b1; i_CPU_we = we; i_CPU_be = be; i_CPU_addr = addr; i_CPU_write = wd;
    end
    got = 1'b0;
    for (int n = 1; n <= 60 && !got; n++) begin
      @(negedge clk);
      if (chk_cmd && n == 2) begin
        chk("grant_we", o_RAM_we, we);
        chk("grant_be", o_RAM_be, be);
        chk("grant_addr", o_RAM_addr, addr);
        if (we) chk("grant_wdata", o_RAM_write, wd);
        chk("grant_no_ack", dma ? o_DMA_ack : o_CPU_ack, 0);
      end
      if (chk_cmd && n == 3) begin
        chk("data_we0", o_RAM_we, 0);
        chk("data_be0", o_RAM_be, 0);
        chk("latency_ack", dma ? o_DMA_ack : o_CPU_ack, 1);
      end
      got = dma ? o_DMA_ack : o_CPU_ack;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: dma=%0b addr=%0h got no ack expected ack", dma, addr);
    end
    @(posedge clk); #1;
    if (last) begin
      if (dma) begin i_DMA_req = 1'b0; i_DMA_lock = 1'b0; end
      else i_CPU_req = 1'b0;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ram_we"},   o_RAM_we, 0);
    chk({tag, "_ram_be"},   o_RAM_be, 0);
    chk({tag, "_ram_addr"}, o_RAM_addr, 0);
    chk({tag, "_ram_wr"},   o_RAM_write, 0);
    chk({tag, "_acks"},     {o_CPU_ack, o_DMA_ack}, 0);
    chk({tag, "_reads"},    {o_CPU_read, o_DMA_read}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    mem[8'h10] = 16'hBEEF;
    mem[8'h20] = 16'hABCD;
    mem[8'h30] = 16'h3333;
    mem[8'h40] = 16'h4444;
    for (int i = 0; i < 10; i++) mem[8'h50 + i] = 16'h5000 + 16'(i);
    reset = 1'b1;
    i_CPU_req = 0; i_CPU_we = 0; i_CPU_be = 0; i_CPU_addr = 0; i_CPU_write = 0;
    i_DMA_req = 0; i_DMA_we = 0; i_DMA_be = 0; i_DMA_addr = 0; i_DMA_write = 0; i_DMA_lock = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Solo CPU read, then byte-masked write and readback
    expect_ack(1'b0, 16'hBEEF);
    acc(1'b0, 1'b0, 2'b11, 18'h00010, 16'h0, 1'b0, 1'b1, 1'b1);
    expect_ack(1'b0, 16'h0000);
    acc(1'b0, 1'b1, 2'b10, 18'h00020, 16'h1234, 1'b0, 1'b1, 1'b1);
    expect_ack(1'b0, 16'h12CD);
    acc(1'b0, 1'b0, 2'b11, 18'h00020, 16'h0, 1'b0, 1'b1, 1'b1);

    // Tie out of reset: CPU first, then alternation
    reset = 1'b1;
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    ack_cycs.delete();
    expect_ack(1'b0, 16'hBEEF);
    expect_ack(1'b1, 16'h3333);
    expect_ack(1'b0, 16'h12CD);
    expect_ack(1'b1, 16'h4444);
    fork
      begin
        acc(1'b0, 1'b0, 2'b11, 18'h10, 16'h0, 1'b0, 1'b0, 1'b0);
        acc(1'b0, 1'b0, 2'b11, 18'h20, 16'h0, 1'b0, 1'b1, 1'b0);
      end
      begin
        acc(1'b1, 1'b0, 2'b11, 18'h30, 16'h0, 1'b0, 1'b0, 1'b0);
        acc(1'b1, 1'b0, 2'b11, 18'h40, 16'h0, 1'b0, 1'b1, 1'b0);
      end
    join
    chk("rr_ack_count", ack_cycs.size(), 4);
    if (ack_cycs.size() == 4)
      for (int i = 1; i < 4; i++) chk("rr_ack_spacing", ack_cycs[i] - ack_cycs[i-1], 3);

    // DMA lock+req held, CPU joins after the first DMA grant
`ifdef RAM_ARB_BURST_EN
    for (int i = 0; i < 9; i++) expect_ack(1'b1, 16'h5000 + 16'(i));
    expect_ack(1'b0, 16'hBEEF);
    expect_ack(1'b1, 16'h5009);
`else
    expect_ack(1'b1, 16'h5000);
    expect_ack(1'b0, 16'hBEEF);
    for (int i = 1; i < 10; i++) expect_ack(1'b1, 16'h5000 + 16'(i));
`endif
    fork
      begin
        for (int i = 0; i < 10; i++)
          acc(1'b1, 1'b0, 2'b11, 18'h50 + 18'(i), 16'h0, 1'b1, i == 9, 1'b0);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        acc(1'b0, 1'b0, 2'b11, 18'h10, 16'h0, 1'b0, 1'b1, 1'b0);
      end
    join

    // Reset during GRANT of a DMA write aborts it
    i_DMA_req = 1'b1; i_DMA_we = 1'b1; i_DMA_be = 2'b11;
    i_DMA_addr = 18'h60; i_DMA_write = 16'h6666;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_grant_we", o_RAM_we, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    i_DMA_req = 1'b0; i_DMA_we = 1'b0;
    @(negedge clk);
    chk_all_zero("abort");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expect_ack(1'b0, 16'hBEEF);
    expect_ack(1'b1, 16'h3333);
    fork
      acc(1'b0, 1'b0, 2'b11, 18'h10, 16'h0, 1'b0, 1'b1, 1'b0);
      acc(1'b1, 1'b0, 2'b11, 18'h30, 16'h0, 1'b0, 1'b1, 1'b0);
    join

    repeat (4) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_arb.md
# ram_arb

Two-port arbiter that shares the single synchronous RAM port between the CPU memory path (from `mem_io`) and a DMA requester, such as a future SD block-transfer engine. It sits between `mem_io`/DMA and `ram`. It sequences each access through a grant/data cycle pair and returns data plus a one-cycle acknowledge to the winning requester. Arbitration is round-robin, with an optional bounded DMA burst lock.

## Interface
Parameters:
- `ADDR_W`, 18, RAM word-address width
- `DATA_W`, 16, data width
- `MAX_BURST`, 8, max consecutive locked DMA grants while the CPU is waiting (≥1)

Ports (one clock `clk`; `reset` is synchronous, active-high):
- `clk` in 1: system clock
- `reset` in 1: synchronous active-high reset
- `i_CPU_req` in 1: CPU access request, held until ack
- `i_CPU_we` in 1: 1 = write, 0 = read
- `i_CPU_be` in 2: byte enables (bit1 = high byte)
- `i_CPU_addr` in ADDR_W: word address
- `i_CPU_write` in DATA_W: write data
- `o_CPU_read` out DATA_W: read data, valid only while `o_CPU_ack`
- `o_CPU_ack` out 1: one-cycle completion pulse
- `i_DMA_req`, `i_DMA_we`, `i_DMA_be`[2], `i_DMA_addr`[ADDR_W], `i_DMA_write`[DATA_W]: as the CPU equivalents
- `i_DMA_lock` in 1: request back-to-back grants (burst)
- `o_DMA_read` out DATA_W, `o_DMA_ack` out 1: as the CPU equivalents
- `o_RAM_addr` out ADDR_W, `o_RAM_write` out DATA_W, `o_RAM_we` out 1, `o_RAM_be` out 2: RAM command
- `i_RAM_read` in DATA_W: RAM read data, one cycle after the address

## Operation
States:
- IDLE
- GRANT: RAM command driven from the winner's registered-select inputs
- DATA: `i_RAM_read` valid; ack pulses

Transitions:
- IDLE → GRANT when any request is high; winner chosen as below.
- GRANT → DATA unconditionally.
- DATA → IDLE unconditionally.

Winner selection in IDLE:
- Only one requester requesting: it wins.
- Both requesting: the one not granted last wins (`last_dma` flag, updated on every grant).
- Lock override: if the DMA won the previous access, `i_DMA_lock` and `i_DMA_req` are both high, and `burst_cnt < MAX_BURST`, the DMA wins even if the CPU is requesting.

Burst counter:
- `burst_cnt` increments on each locked DMA grant made while `i_CPU_req` is high.
- It clears on any CPU grant or any unlocked grant.

Outputs by state:
- GRANT: `o_RAM_we` equals the winner's `we`; `o_RAM_be`, `o_RAM_addr` and `o_RAM_write` are from the winner.
- Other states: `o_RAM_we`=0 and `o_RAM_be`=0; addr and write data hold their last value.
- DATA: the winner's ack is 1. Its read port = `i_RAM_read` for reads and 0 for writes. The non-winner's read port is 0.

Requester rules:
- Inputs must be held stable from req rise through ack.
- Drop req in the cycle after ack unless another access is wanted.
- If req drops during GRANT/DATA, the access still completes and the ack still pulses.

Reset:
- State = IDLE, `last_dma`=1 (the CPU wins the first tie), `burst_cnt`=0.
- All outputs 0.
- Reset in GRANT or DATA aborts the access: no ack is issued, and `o_RAM_we`=0 from the first reset edge onward.

## Timing
- Request seen in IDLE at cycle N: GRANT at N+1 (RAM write occurs at the end of N+1), DATA/ack at N+2, IDLE at N+3.
- Fixed latency: 2 cycles from request sample to ack.
- Throughput: one access per 3 cycles.
- Acks are mutually exclusive and never back-to-back (at least 2 cycles apart).
- CPU worst-case wait with the lock enabled: (MAX_BURST + 1) × 3 cycles before its GRANT.

## Configuration
- `RAM_ARB_BURST_EN` defined: `i_DMA_lock` and the `burst_cnt` logic are compiled in, as described above.
- Not defined: `i_DMA_lock` is ignored and there is no burst counter. Pure round-robin applies, and the CPU is granted within one DMA access (≤3 cycles) of requesting.

## Test plan
- CPU read, addr 0x00010, RAM holds 0xBEEF, DMA idle → `o_RAM_we`=0 in GRANT; `o_CPU_ack`=1 with `o_CPU_read`=0xBEEF exactly 2 cycles after req sampled; `o_DMA_ack` stays 0.
- CPU write 0x1234 with be=2'b10 to 0x00020, then read back → `o_RAM_be`=2'b10 for one GRANT cycle; readback high byte = 0x12, low byte unchanged.
- Both req asserted in the same cycle out of reset, held for 4 accesses → grant order CPU, DMA, CPU, DMA; acks 3 cycles apart.
- Macro on, MAX_BURST=8, DMA lock+req held, CPU requests after the first DMA grant → 8 further consecutive DMA acks, then a CPU ack; `burst_cnt` back to 0.
- Macro off, same stimulus → alternating DMA/CPU acks.
- Reset asserted during GRANT of a DMA write → no `o_DMA_ack`, `o_RAM_we`=0 after the reset edge, all outputs 0; the first post-reset tie goes to the CPU.
